// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and two-state instruction fetch stage
// Optional retire/stall counters are enabled with `define PC_FETCH_PERF_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] ILLOP_PC = 32'h80000004,
  parameter logic [31:0] XADR_PC  = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        ALUOut0,
  input  logic [31:0] DataBusA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruct,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        jiandu
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] fetch_stall_cnt
`endif
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;

  logic [0:0]  state;
  logic [31:0] next_pc;
  logic [30:0] br_off;

  // Reset gates the handshake outputs so nothing escapes in the reset cycle.
  assign imem_req    = (state == FETCH) && !reset;
  assign instr_valid = (state == EXEC) && !reset;
  assign imem_addr   = {PC[31:2], 2'b00};
  assign PC_plus4    = {PC[31], PC[30:0] + 31'd4};
  assign jiandu      = PC[31];
  assign br_off      = {{13{Instruct[15]}}, Instruct[15:0], 2'b00};

  always_comb begin
    next_pc = PC_plus4;
    case (PCSrc)
      3'd0: next_pc = PC_plus4;
      3'd1: next_pc = ALUOut0 ? {PC_plus4[31], PC_plus4[30:0] + br_off} : PC_plus4;
      3'd2: next_pc = {PC_plus4[31:28], Instruct[25:0], 2'b00};
      // jr may drop supervisor but can never raise it
      3'd3: next_pc = {PC[31] & DataBusA[31], DataBusA[30:0]};
      3'd4: next_pc = ILLOP_PC;
      default: next_pc = XADR_PC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      PC       <= RESET_PC;
      Instruct <= 32'h0;
    end else if (state == FETCH) begin
      if (imem_ready) begin
        Instruct <= imem_rdata;
        state    <= EXEC;
      end
    end else begin
      PC    <= next_pc;
      state <= FETCH;
    end
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt     <= 32'h0;
      fetch_stall_cnt <= 32'h0;
    end else begin
      if (state == EXEC) retired_cnt <= retired_cnt + 32'd1;
      if (state == FETCH && !imem_ready) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - randomized and directed checks of pc_fetch against an instruction-level model
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        ALUOut0;
  logic [31:0] DataBusA;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruct;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        jiandu;

  int checks = 0;
  int passed = 0;

  // model: which half of the instruction we are in, plus architectural PC and latched word
  bit          m_known = 0;
  bit          m_waiting = 1;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  pc_fetch dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .ALUOut0(ALUOut0), .DataBusA(DataBusA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .Instruct(Instruct), .instr_valid(instr_valid),
    .PC(PC), .PC_plus4(PC_plus4), .jiandu(jiandu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] seq4(input logic [31:0] p);
    logic [31:0] s;
    s = p + 32'd4;
    return {p[31], s[30:0]};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [2:0] src, input logic c,
                                             input logic [31:0] a);
    logic [31:0] s;
    logic [31:0] off;
    logic [31:0] t;
    s = seq4(p);
    off = 32'($signed(ins[15:0])) * 4;
    t = s + off;
    if (src == 3'd0) return s;
    if (src == 3'd1) return c ? {s[31], t[30:0]} : s;
    if (src == 3'd2) return {s[31:28], ins[25:0], 2'b00};
    if (src == 3'd3) return {(p[31] && a[31]) ? 1'b1 : 1'b0, a[30:0]};
    if (src == 3'd4) return 32'h80000004;
    return 32'h80000008;
  endfunction

  task automatic step(input logic r, input logic rdy, input logic [31:0] rd,
                      input logic [2:0] src, input logic c, input logic [31:0] a);
    @(negedge clk);
    reset = r; imem_ready = rdy; imem_rdata = rd; PCSrc = src; ALUOut0 = c; DataBusA = a;
    #1;
    chk("imem_req", 32'(imem_req), 32'(!r && (m_waiting || !m_known)));
    chk("instr_valid", 32'(instr_valid), 32'(!r && !m_waiting && m_known));
    if (m_known) begin
      chk("PC", PC, m_pc);
      chk("imem_addr", imem_addr, m_pc & 32'hFFFFFFFC);
      chk("PC_plus4", PC_plus4, seq4(m_pc));
      chk("jiandu", 32'(jiandu), 32'(m_pc[31]));
      chk("Instruct", Instruct, m_instr);
    end
    if (r) begin
      m_known = 1; m_waiting = 1; m_pc = 32'h80000000; m_instr = 32'h0;
    end else if (m_known && m_waiting) begin
      if (rdy) begin m_instr = rd; m_waiting = 0; end
    end else if (m_known) begin
      m_pc = model_next(m_pc, m_instr, src, c, a);
      m_waiting = 1;
    end
  endtask

  // one whole instruction: fetch with ready, then execute with given select
  task automatic instr(input logic [31:0] word, input logic [2:0] src, input logic c,
                       input logic [31:0] a);
    step(0, 1, word, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, src, c, a);
  endtask

  initial begin
    int pulses;
    int reqs;
    logic [31:0] held;
    step(1, 1, 32'h12345678, 3'd0, 0, 32'h0);
    step(1, 1, 32'h12345678, 3'd0, 0, 32'h0);
    chk("reset_PC", PC, 32'h80000000);
    chk("reset_Instruct", Instruct, 32'h0);

    step(0, 1, 32'h00000000, 3'd0, 0, 32'h0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h80000000);
    step(0, 1, 32'h0, 3'd0, 0, 32'h0);
    chk("first_valid", 32'(instr_valid), 32'd1);
    step(0, 1, 32'hAAAA5555, 3'd0, 0, 32'h0);
    chk("seq_addr", imem_addr, 32'h80000004);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);

    // wait states: ready late, Instruct only moves on the ready edge
    pulses = 0; reqs = 0; held = Instruct;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'hDEAD0000 + 32'(i), 3'd0, 0, 32'h0);
      reqs += int'(imem_req); pulses += int'(instr_valid);
      chk("stall_hold", Instruct, held);
    end
    step(0, 1, 32'h3C010001, 3'd0, 0, 32'h0);
    reqs += int'(imem_req); pulses += int'(instr_valid);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    pulses += int'(instr_valid);
    chk("stall_reqs", 32'(reqs), 32'd4);
    chk("stall_pulses", 32'(pulses), 32'd1);
    chk("stall_word", Instruct, 32'h3C010001);

    // jr from kernel to 0x10, then branch with imm=-1
    instr(32'h0, 3'd3, 0, 32'h00000010);
    instr(32'h0000FFFF, 3'd1, 1, 32'h0);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("br_taken", imem_addr, 32'h00000010);
    step(0, 1, 32'h0000FFFF, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, 3'd1, 0, 32'h0);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("br_not", imem_addr, 32'h00000014);

    // kernel jr clears supervisor; user jr cannot set it
    step(0, 1, 32'h0, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, 3'd4, 0, 32'h0);
    instr(32'h0, 3'd3, 0, 32'h80000100);
    instr(32'h0, 3'd3, 0, 32'h00400000);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("jr_pc", PC, 32'h00400000);
    chk("jr_jiandu", 32'(jiandu), 32'd0);
    step(0, 1, 32'h0, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, 3'd3, 0, 32'h80000000);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("jr_user_pc", PC, 32'h00000000);
    chk("jr_user_jiandu", 32'(jiandu), 32'd0);

    // vectors from user mode
    step(0, 1, 32'h0, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, 3'd4, 0, 32'h0);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("illop_pc", PC, 32'h80000004);
    chk("illop_jiandu", 32'(jiandu), 32'd1);
    step(0, 1, 32'h0, 3'd0, 0, 32'h0);
    step(0, 0, 32'h0, 3'd7, 0, 32'h0);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("xadr_pc", PC, 32'h80000008);

    // reset during a ready FETCH cycle
    step(1, 1, 32'hCAFEF00D, 3'd0, 0, 32'h0);
    chk("rst_fetch_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 32'h0, 3'd0, 0, 32'h0);
    chk("rst_fetch_Instruct", Instruct, 32'h0);
    chk("rst_fetch_PC", PC, 32'h80000000);
    chk("rst_fetch_valid2", 32'(instr_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 1)), $urandom,
           3'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter and instruction-fetch stage directly upstream of the main decoder. Holds the PC and the supervisor bit, fetches one instruction word per instruction over a ready-handshaked instruction-memory port, and presents it on Instruct with a one-cycle instr_valid qualifier. Consumes the decoder's PCSrc selection and branch condition to compute the next PC, including the interrupt and illegal-instruction vectors.

Parameters:
RESET_PC, 32'h80000000, PC value after reset (kernel mode)
ILLOP_PC, 32'h80000004, interrupt vector (PCSrc=4)
XADR_PC, 32'h80000008, exception vector (PCSrc=5, 6, 7)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
PCSrc  in  3  next-PC select from the decoder
ALUOut0  in  1  branch condition (bit 0 of the ALU result)
DataBusA  in  32  rs register value, used as the jr/jalr target
imem_req  out  1  fetch request
imem_addr  out  32  word-aligned fetch address {PC[31:2],2'b00}
imem_ready  in  1  memory has returned data this cycle
imem_rdata  in  32  instruction word, valid when imem_ready=1
Instruct  out  32  latched instruction to the decoder
instr_valid  out  1  Instruct is executing this cycle; the CPU gates all architectural writes with it
PC  out  32  current PC
PC_plus4  out  32  {PC[31], PC[30:0]+31'd4}, link/EPC value
jiandu  out  1  supervisor flag, equal to PC[31]

Behaviour:
- States: FETCH and EXEC.
- Reset (synchronous, overrides everything, including mid-fetch and EXEC):
  - state=FETCH, PC=RESET_PC, Instruct=0, instr_valid=0.
  - imem_req=0 in the reset cycle; the first request is issued in the cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr from the current PC, instr_valid=0.
  - On imem_ready=1: Instruct<=imem_rdata, go to EXEC.
  - Otherwise stay in FETCH; wait states are unbounded.
  - PC and Instruct are held while in FETCH.
- EXEC (exactly one cycle):
  - imem_req=0, instr_valid=1.
  - At the clock edge: PC<=next PC, go to FETCH.
  - Minimum of 2 cycles per instruction.
- imem_ready while not in FETCH: ignored.
- Next-PC selection (evaluated from inputs in the EXEC cycle only):
  - PCSrc=0: PC_plus4.
  - PCSrc=1: if ALUOut0, branch target {PC_plus4[31], PC_plus4[30:0] + ({{13{imm[15]}},imm,2'b00})[30:0]}, where imm=Instruct[15:0], wrap-around at 31 bits; else PC_plus4.
  - PCSrc=2: {PC_plus4[31:28], Instruct[25:0], 2'b00}.
  - PCSrc=3: {PC[31] & DataBusA[31], DataBusA[30:0]}. Supervisor can only be cleared via jr, never set.
  - PCSrc=4: ILLOP_PC.
  - PCSrc=5, 6 or 7: XADR_PC.
- Bit-31 rules:
  - Sequential, branch and jump targets preserve PC[31].
  - Only the vectors, reset, and a kernel-mode jr can place 1 in bit 31.
- Address alignment: PC[1:0] is stored as computed; imem_addr always forces bits 1:0 to 0.
- PC_plus4 and jiandu are combinational from the PC register.
- Instruct holds its last value outside EXEC; downstream must qualify it with instr_valid.

Optional Feature:
Macro PC_FETCH_PERF_EN.
- Defined:
  - Extra output port retired_cnt, 32 bits.
  - Reset to 0; increments by 1 at the end of every EXEC cycle; wraps 32'hFFFFFFFF -> 0.
  - Extra output port fetch_stall_cnt, 32 bits, increments for every FETCH cycle with imem_ready=0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset held 2 cycles, then released, imem_ready tied 1 -> cycle after release: imem_req=1, imem_addr=0x80000000. Next cycle: instr_valid=1. With PCSrc=0, the following request has imem_addr=0x80000004.
- imem_ready delayed 3 cycles, rdata=0x3C010001 -> imem_req stays high for 4 cycles, Instruct changes only on the ready cycle, exactly one instr_valid pulse.
- PC=0x00000010, Instruct imm=0xFFFF, PCSrc=1, ALUOut0=1 -> next imem_addr=0x00000010. Same with ALUOut0=0 -> 0x00000014.
- PC=0x80000100, PCSrc=3, DataBusA=0x00400000 -> PC=0x00400000, jiandu=0. Then PCSrc=3, DataBusA=0x80000000 from user mode -> PC=0x00000000, jiandu stays 0.
- User mode, EXEC cycle: PCSrc=4 -> PC=0x80000004, jiandu=1. PCSrc=7 -> PC=0x80000008.
- Reset asserted in a FETCH cycle with imem_ready=1 -> Instruct stays 0, PC=0x80000000, no instr_valid pulse.
